// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI shift engine.
//   spi_state_e : engine state encoding (S_IDLE, S_SHIFT, S_FINISH)
//   SS_*        : bit positions in the slave-select vector
//   MOSI_IDLE   : level driven on mosi outside a transfer
//   RX_RESET    : receive register reset value
package spi_pkg;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } spi_state_e;

  localparam int SS_SD0 = 0;
  localparam int SS_SD1 = 1;
  localparam int SS_ETH = 2;

  localparam logic       MOSI_IDLE = 1'b1;
  localparam logic [7:0] RX_RESET  = 8'hFF;
endpackage

// File: rtl/spi_shift_engine_if.sv
// spi_shift_engine_if: CIA-side register bus of the SPI shift engine.
//   master modport : register decode (drives start/tx_data/div/ss_wr/ss_in/rd_strobe)
//   slave modport  : shift engine (drives rx_data/busy/done)
interface spi_shift_engine_if #(
  parameter int DIV_W  = 8,
  parameter int NUM_SS = 3
);
  logic              start;
  logic [7:0]        tx_data;
  logic [DIV_W-1:0]  div;
  logic              ss_wr;
  logic [NUM_SS-1:0] ss_in;
  logic              rd_strobe;
  logic [7:0]        rx_data;
  logic              busy;
  logic              done;

  modport master (
    output start, tx_data, div, ss_wr, ss_in, rd_strobe,
    input  rx_data, busy, done
  );

  modport slave (
    input  start, tx_data, div, ss_wr, ss_in, rd_strobe,
    output rx_data, busy, done
  );
endinterface

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period tick generator.
//   clk, _reset : clock, synchronous active-low reset
//   reload      : half-period length minus 1
//   en          : count while high
//   restart     : load reload, no tick this cycle
//   tick        : high on the last cycle of each half-period
module spi_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             _reset,
  input  logic [DIV_W-1:0] reload,
  input  logic             en,
  input  logic             restart,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!_reset)      cnt <= '0;
    else if (restart) cnt <= reload;
    else if (en)      cnt <= (cnt == '0) ? reload : cnt - DIV_W'(1);
  end

  assign tick = en && !restart && (cnt == '0);
endmodule

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: byte-serial SPI mode-0 master behind the CIA register decode.
//   clk, _reset : clock, synchronous active-low reset
//   bus         : CIA register bus (slave modport)
//   miso        : serial data in
//   mosi, sclk  : serial data out, SPI clock (idle low)
//   _ss         : active-low slave selects (bit0 SD0, bit1 SD1, bit2 Ethernet)
// Optional build macro SPI_AUTO_READ_EN: rd_strobe in idle launches an 8'hFF
// transfer (fast SD block-read path).
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DIV_W  = 8,
  parameter int NUM_SS = 3
) (
  input  logic              clk,
  input  logic              _reset,
  spi_shift_engine_if.slave bus,
  input  logic              miso,
  output logic              mosi,
  output logic              sclk,
  output logic [NUM_SS-1:0] _ss
);
  spi_state_e        state, state_nx;
  logic              go, accept, tick, last;
  logic [7:0]        go_data, tx_sh, rx_sh, rx_q;
  logic [3:0]        hp_cnt;
  logic [DIV_W-1:0]  div_q;
  logic [NUM_SS-1:0] ss_q, pend_val;
  logic              pend_vld;

`ifdef SPI_AUTO_READ_EN
  // start has priority over the auto-read strobe
  assign go      = bus.start | bus.rd_strobe;
  assign go_data = bus.start ? bus.tx_data : 8'hFF;
`else
  logic unused_rd;
  assign unused_rd = bus.rd_strobe;
  assign go        = bus.start;
  assign go_data   = bus.tx_data;
`endif

  assign accept = (state == S_IDLE) && go;
  assign last   = tick && (hp_cnt == 4'd15);

  // In idle the divider tracks the live div so restart loads it directly.
  spi_clk_div #(.DIV_W(DIV_W)) u_clk_div (
    .clk     (clk),
    ._reset  (_reset),
    .reload  ((state == S_IDLE) ? bus.div : div_q),
    .en      (state == S_SHIFT),
    .restart (accept),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!_reset) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (go)   state_nx = S_SHIFT;
      S_SHIFT:  if (last) state_nx = S_FINISH;
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!_reset) begin
      sclk     <= 1'b0;
      hp_cnt   <= '0;
      tx_sh    <= 8'hFF;
      rx_sh    <= RX_RESET;
      rx_q     <= RX_RESET;
      div_q    <= '0;
      ss_q     <= '0;
      pend_val <= '0;
      pend_vld <= 1'b0;
    end else begin
      if (accept) begin
        tx_sh  <= go_data;
        div_q  <= bus.div;
        hp_cnt <= '0;
        sclk   <= 1'b0;
      end else if (tick) begin
        hp_cnt <= hp_cnt + 4'd1;
        sclk   <= ~hp_cnt[0];
        // even half-period end = rising edge (sample), odd = falling (shift)
        if (!hp_cnt[0]) rx_sh <= {rx_sh[6:0], miso};
        else            tx_sh <= {tx_sh[6:0], 1'b0};
      end

      if (last) rx_q <= rx_sh;

      // Selects only move outside the byte; a write during SHIFT is parked
      // and applied on entry to FINISH (a write on that very edge wins).
      if (state == S_SHIFT) begin
        if (last) begin
          if (bus.ss_wr)    ss_q <= bus.ss_in;
          else if (pend_vld) ss_q <= pend_val;
          pend_vld <= 1'b0;
        end else if (bus.ss_wr) begin
          pend_val <= bus.ss_in;
          pend_vld <= 1'b1;
        end
      end else if (bus.ss_wr) begin
        ss_q <= bus.ss_in;
      end
    end
  end

  assign mosi        = (state == S_SHIFT) ? tx_sh[7] : MOSI_IDLE;
  assign _ss         = ~ss_q;
  assign bus.rx_data = rx_q;
  assign bus.busy    = (state == S_SHIFT);
  assign bus.done    = (state == S_FINISH);
endmodule

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine: scoreboard bench for spi_shift_engine. Expected receive
// bytes are queued at launch and compared when done pulses.
module tb_spi_shift_engine;
  localparam int DIV_W  = 8;
  localparam int NUM_SS = 3;

  logic              clk = 1'b0;
  logic              _reset = 1'b0;
  logic              miso, mosi, sclk;
  logic [NUM_SS-1:0] _ss;

  spi_shift_engine_if #(.DIV_W(DIV_W), .NUM_SS(NUM_SS)) bus ();

  spi_shift_engine #(.DIV_W(DIV_W), .NUM_SS(NUM_SS)) dut (
    .clk    (clk),
    ._reset (_reset),
    .bus    (bus),
    .miso   (miso),
    .mosi   (mosi),
    .sclk   (sclk),
    ._ss    (_ss)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, last_done_cyc = 0, rises = 0, mosi_lo = 0;
  int mmode = 0, rbase = 0;
  logic [7:0] pat = 8'h00;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge sclk) rises++;
  always @(negedge clk) if (bus.busy && !mosi) mosi_lo++;

  // miso source: 0 = tied low, 1 = looped from mosi, 2 = pattern MSB first
  assign miso = (mmode == 1) ? mosi :
                (mmode == 2) ? pat[3'(7 - (rises - rbase))] : 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      done_cnt++;
      last_done_cyc = cyc;
      if (exp_q.size() == 0) chk("unexpected_done", {31'd0, bus.done}, 32'd0);
      else                   chk("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int n0, input int bound);
    int k = 0;
    while (done_cnt == n0 && k < bound) begin
      step();
      k++;
    end
    if (done_cnt == n0) chk("done_timeout", done_cnt, n0 + 1);
  endtask

  task automatic xfer(input logic st, input logic rd, input logic [7:0] tx,
                      input logic [7:0] dv, input logic [7:0] exp,
                      input logic ss_en, input logic [2:0] ssv);
    int n0, c0, r0;
    n0 = done_cnt; c0 = cyc; r0 = rises;
    exp_q.push_back(exp);
    bus.start = st; bus.rd_strobe = rd; bus.tx_data = tx; bus.div = dv;
    bus.ss_wr = ss_en; bus.ss_in = ssv;
    step();
    bus.start = 1'b0; bus.rd_strobe = 1'b0; bus.ss_wr = 1'b0;
    bus.tx_data = 8'($urandom); bus.div = 8'($urandom);
    chk("busy_c1", {31'd0, bus.busy}, 32'd1);
    chk("mosi_c1", {31'd0, mosi}, {31'd0, st ? tx[7] : 1'b1});
    if (ss_en) begin
      chk("ss_pre_sclk", {29'd0, _ss}, {29'd0, 3'(~ssv)});
      chk("sclk_c1", {31'd0, sclk}, 32'd0);
    end
    wait_done(n0, 16 * (dv + 1) + 10);
    chk("latency", last_done_cyc - c0, 16 * (dv + 1) + 1);
    chk("sclk_rises", rises - r0, 8);
    step();
    chk("busy_after", {31'd0, bus.busy}, 32'd0);
    chk("sclk_idle", {31'd0, sclk}, 32'd0);
    chk("mosi_idle", {31'd0, mosi}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int n0, c0;
    bus.start = 1'b0; bus.tx_data = 8'h00; bus.div = '0; bus.ss_wr = 1'b0;
    bus.ss_in = '0; bus.rd_strobe = 1'b0;
    repeat (3) step();
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd1);
    chk("rst_ss", {29'd0, _ss}, 32'd7);
    chk("rst_rx", {24'd0, bus.rx_data}, 32'hFF);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    _reset = 1'b1;
    step();

    // idle select write takes effect next cycle
    bus.ss_wr = 1'b1; bus.ss_in = 3'b010;
    step();
    bus.ss_wr = 1'b0;
    chk("ss_idle", {29'd0, _ss}, 32'b101);

    // reset in the middle of a transfer aborts with no done
    bus.start = 1'b1; bus.tx_data = 8'h3C; bus.div = 8'd3;
    step();
    bus.start = 1'b0;
    repeat (10) step();
    chk("mid_busy", {31'd0, bus.busy}, 32'd1);
    _reset = 1'b0;
    repeat (3) step();
    chk("abort_sclk", {31'd0, sclk}, 32'd0);
    chk("abort_mosi", {31'd0, mosi}, 32'd1);
    chk("abort_ss", {29'd0, _ss}, 32'd7);
    chk("abort_rx", {24'd0, bus.rx_data}, 32'hFF);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    _reset = 1'b1;
    n0 = done_cnt;
    repeat (80) step();
    chk("no_done_after_abort", done_cnt, n0);

    // div=0 loopback, div=3 miso low
    mmode = 1; xfer(1'b1, 1'b0, 8'hA5, 8'd0, 8'hA5, 1'b0, 3'b000);
    mmode = 0; xfer(1'b1, 1'b0, 8'h3C, 8'd3, 8'h00, 1'b0, 3'b000);

    // select write during the byte is deferred to FINISH; extra starts ignored
    mmode = 1;
    exp_q.push_back(8'h96);
    bus.div = 8'd1;
    c0 = cyc;
    for (int c = 0; c <= 36; c++) begin
      if (c >= 1 && c <= 32) chk("ss_hold", {29'd0, _ss}, 32'b111);
      if (c >= 33) chk("ss_finish", {29'd0, _ss}, 32'b011);
      if (c == 33) chk("done_c33", {31'd0, bus.done}, 32'd1);
      bus.start   = (c == 0 || c == 5 || c == 20);
      bus.tx_data = (c == 0) ? 8'h96 : 8'h00;
      bus.ss_wr   = (c == 10);
      bus.ss_in   = (c == 10) ? 3'b100 : 3'b000;
      step();
    end
    bus.start = 1'b0; bus.ss_wr = 1'b0;
    chk("defer_latency", last_done_cyc - c0, 33);

    // select write together with start
    xfer(1'b1, 1'b0, 8'h5C, 8'd2, 8'h5C, 1'b1, 3'b001);

`ifdef SPI_AUTO_READ_EN
    mmode = 2; pat = 8'h5A; rbase = rises; n0 = mosi_lo;
    xfer(1'b0, 1'b1, 8'h00, 8'd1, 8'h5A, 1'b0, 3'b000);
    chk("auto_mosi_high", mosi_lo - n0, 0);
    mmode = 1;
    xfer(1'b1, 1'b1, 8'h3A, 8'd0, 8'h3A, 1'b0, 3'b000);
`else
    bus.rd_strobe = 1'b1;
    step();
    bus.rd_strobe = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rd_no_busy", {31'd0, bus.busy}, 32'd0);
      step();
    end
`endif

    repeat (5) step();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
- Byte-serial SPI master engine sitting directly downstream of the CIA register decode in the A500 SD+ controller.
- Takes a byte write from the CIA data register and shifts it out on MOSI/SCLK (SPI mode 0) while capturing MISO.
- Holds the received byte and a slave-select register that drives the SD0, SD1 and Ethernet selects.
- Programmable SCLK divider: slow clock for SD init, fast clock for data transfer.

Parameters:
- DIV_W, 8, width of clock divider value.
- NUM_SS, 3, number of active-low slave selects (bit0 SD0, bit1 SD1, bit2 Ethernet).

Ports:
- clk  input  1  system clock
- _reset  input  1  reset; synchronous, active-low
- start  input  1  one-cycle strobe: begin transfer of tx_data
- tx_data  input  8  byte to send
- div  input  DIV_W  half-period length minus 1, in clk cycles
- ss_wr  input  1  one-cycle strobe: load ss_in
- ss_in  input  NUM_SS  requested select pattern (1 = select that slave)
- rd_strobe  input  1  CIA read of the rx register (used only with SPI_AUTO_READ_EN)
- miso  input  1  serial data in, already muxed
- mosi  output  1  serial data out
- sclk  output  1  SPI clock, idle low
- _ss  output  NUM_SS  active-low slave selects
- rx_data  output  8  last received byte
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse at end of transfer

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - All state resets synchronously while _reset=0.
  - Reset values: sclk=0, mosi=1, _ss=all ones, rx_data=8'hFF, busy=0, done=0, pending-ss flag=0.
  - Reset mid-transfer aborts immediately; no done pulse is generated.
- States and transitions:
  - IDLE -> SHIFT on start while idle.
  - SHIFT -> FINISH after the 16th half-period.
  - FINISH -> IDLE after one cycle.
- Start (cycle 0, start sampled in IDLE):
  - Latch tx_data into the shift register and div into the divider reload.
  - Drive mosi=tx_data[7]; busy=1 from cycle 1.
- Half-period counter:
  - Loads the latched div and counts down to 0.
  - Each half-period lasts div+1 cycles; div=0 gives SCLK = clk/2.
- Edge ordering:
  - Even half-period ends: sclk rises; miso is sampled into the LSB of the rx shift register.
  - Odd half-period ends: sclk falls; the tx shift register shifts left and mosi shows the next bit.
  - 16 half-periods per byte, MSB first.
- FINISH:
  - rx_data is updated from the rx shift register; done=1 for exactly one cycle.
  - busy=0 in the same cycle as done.
  - mosi returns to 1; sclk stays 0.
- Latency: done asserts in cycle 16*(div+1)+1 after the start cycle.
- start while busy (including the FINISH cycle): ignored, with no effect on the current transfer.
- div changes while busy: no effect until the next start.
- ss_wr while IDLE: _ss = ~ss_in on the next cycle.
- ss_wr while busy:
  - Value is held in a pending register.
  - Applied in the FINISH cycle, so the select cannot change mid-byte.
  - A later ss_wr overwrites the pending value.
- ss_wr and start in the same IDLE cycle: both take effect; the new select is valid before the first sclk edge.
- ss_in with multiple bits set is passed through unchanged (software responsibility).
- rx_data is stable between done pulses.

Optional Feature:
- Macro: SPI_AUTO_READ_EN.
- When defined:
  - rd_strobe while IDLE starts a transfer with tx byte 8'hFF; this is the fast SD block-read path.
  - rd_strobe while busy is ignored.
  - rd_strobe and start in the same cycle: start wins, using tx_data.
- When undefined: rd_strobe is unused and has no effect; behaviour is identical to the description above.

Decomposition:
- Shared package spi_pkg holds:
  - state encoding localparams (S_IDLE, S_SHIFT, S_FINISH);
  - SS bit indices (SS_SD0=0, SS_SD1=1, SS_ETH=2);
  - idle constants (MOSI_IDLE=1, RX_RESET=8'hFF).
- One natural sub-module: spi_clk_div. It takes the reload value, enable and restart, and produces a half-period tick; it is reusable by a future Ethernet-only engine.

Test Plan:
- Reset: hold _reset=0 for 3 cycles mid-transfer -> sclk=0, mosi=1, _ss=3'b111, rx_data=8'hFF, busy=0, no done.
- div=0, tx_data=8'hA5, miso looped to mosi -> 8 sclk rising edges; done at cycle 17; rx_data=8'hA5.
- div=3, tx_data=8'h3C, miso tied 0 -> each sclk phase 4 cycles; done at cycle 65; rx_data=8'h00.
- Transfer running, ss_wr with ss_in=3'b100 at cycle 10 -> _ss unchanged until the FINISH cycle, then 3'b011; start pulses at cycles 5 and 20 are ignored.
- IDLE, ss_wr=1 with ss_in=3'b001 and start in the same cycle -> _ss=3'b110 before the first sclk rise; normal transfer follows.
- SPI_AUTO_READ_EN defined, rd_strobe in IDLE, miso driving 8'h5A -> mosi stays 1 for all bits; rx_data=8'h5A after done. Without the macro -> busy stays 0.
